// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
// Shared types and helpers for the pipelined adder/subtractor.
//   op_e        : operation select encoding carried on the 'mode' input
//   num_stages  : ceiling division used to size the pipeline from N and SEG
// ----------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Number of SEG-bit slices needed to cover an n-bit word.
   function automatic int num_stages(input int n, input int seg);
      return (n + seg - 1) / seg;
   endfunction

endpackage

// File: rtl/addsub_seg.sv
// ----------------------------------------------------------------------------
// addsub_seg
// Combinational W-bit carry-ripple slice built from 1-bit full-adder cells.
// Ports:
//   a      in  W  operand A bits of this slice
//   b_eff  in  W  operand B bits, already inverted for subtraction
//   cin    in  1  carry into the slice LSB
//   sum    out W  slice sum
//   cout   out 1  carry out of the slice MSB
// ----------------------------------------------------------------------------
module addsub_seg
   import addsub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b_eff,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic carry;

   // Ripple through the cells LSB first; 'carry' holds the carry into bit i.
   always_comb begin
      carry = cin;
      sum   = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b_eff[i] ^ carry;
         carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/addsub_pipe.sv
// ----------------------------------------------------------------------------
// addsub_pipe
// Pipelined N-bit adder/subtractor. The word is cut into SEG-bit slices; slice
// k is computed in stage k from the carry registered by stage k-1, so the
// critical path is one SEG-bit ripple regardless of N. Operands travel with
// the beat (skew) and finished sum slices travel behind it (deskew), so the
// whole result word is aligned at the last register. Backpressure freezes the
// entire pipeline.
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   in_valid   in  1  operand beat valid
//   in_ready   out 1  beat accepted this cycle when in_valid is also high
//   a, b       in  N  operands (unsigned or two's complement)
//   mode       in  1  0 = A+B, 1 = A-B
//   out_valid  out 1  result beat valid
//   out_ready  in  1  downstream accepts result
//   res        out N  result modulo 2^N
//   cout       out 1  carry out of MSB
//   borrow     out 1  unsigned A<B on subtract
//   ovf        out 1  signed overflow
//   zero       out 1  res == 0
// All result outputs read 0 whenever out_valid is low.
// ----------------------------------------------------------------------------
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int N   = 8,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] res,
   output logic         cout,
   output logic         borrow,
   output logic         ovf,
   output logic         zero
);

   localparam int STAGES = num_stages(N, SEG);
   localparam int LAST   = STAGES - 1;

   // Register bank after each stage k (index k = output of stage k).
   logic [N-1:0] a_reg [STAGES];
   logic [N-1:0] b_reg [STAGES];   // effective B (inverted on subtract)
   logic [N-1:0] s_reg [STAGES];   // sum bits completed so far
   logic         c_reg [STAGES];   // carry out of the slice just computed
   logic         m_reg [STAGES];
   logic         v_reg [STAGES];

   // Inputs seen by each stage: ports for stage 0, previous bank otherwise.
   logic [N-1:0] stg_a [STAGES];
   logic [N-1:0] stg_b [STAGES];
   logic [N-1:0] stg_s [STAGES];
   logic         stg_c [STAGES];
   logic         stg_m [STAGES];
   logic         stg_v [STAGES];

   // Stage results to be captured into the bank.
   logic [N-1:0] s_next [STAGES];
   logic         c_next [STAGES];

   op_e          op;
   logic [N-1:0] b_eff_in;
   logic         stall;

   assign op       = op_e'(mode);
   assign b_eff_in = (op == OP_SUB) ? ~b : b;

   // Global stall: the only place a beat can be blocked is the output.
   assign stall    = v_reg[LAST] & ~out_ready;
   assign in_ready = ~stall;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int LO = gi * SEG;
         localparam int W  = ((N - LO) < SEG) ? (N - LO) : SEG;
         // Bits of the result word owned by this slice.
         localparam logic [N-1:0] SLICE_MASK = ({N{1'b1}} >> (N - W)) << LO;

         logic [W-1:0] slice_sum;
         logic         slice_cout;

         if (gi == 0) begin : g_head
            assign stg_a[gi] = a;
            assign stg_b[gi] = b_eff_in;
            assign stg_s[gi] = '0;
            assign stg_c[gi] = mode;   // +1 completes the two's complement of B
            assign stg_m[gi] = mode;
            assign stg_v[gi] = in_valid;
         end else begin : g_body
            assign stg_a[gi] = a_reg[gi-1];
            assign stg_b[gi] = b_reg[gi-1];
            assign stg_s[gi] = s_reg[gi-1];
            assign stg_c[gi] = c_reg[gi-1];
            assign stg_m[gi] = m_reg[gi-1];
            assign stg_v[gi] = v_reg[gi-1];
         end

         addsub_seg #(
            .W (W)
         ) u_seg (
            .a     (stg_a[gi][LO +: W]),
            .b_eff (stg_b[gi][LO +: W]),
            .cin   (stg_c[gi]),
            .sum   (slice_sum),
            .cout  (slice_cout)
         );

         assign s_next[gi] = (stg_s[gi] & ~SLICE_MASK) | (N'(slice_sum) << LO);
         assign c_next[gi] = slice_cout;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k] <= '0;
            b_reg[k] <= '0;
            s_reg[k] <= '0;
            c_reg[k] <= 1'b0;
            m_reg[k] <= 1'b0;
            v_reg[k] <= 1'b0;
         end
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k] <= stg_a[k];
            b_reg[k] <= stg_b[k];
            s_reg[k] <= s_next[k];
            c_reg[k] <= c_next[k];
            m_reg[k] <= stg_m[k];
            v_reg[k] <= stg_v[k];
         end
      end
   end

   // Flags come straight from the final bank; everything is gated by valid so
   // stale data in an empty stage never reaches the outputs.
   assign out_valid = v_reg[LAST];
   assign res       = out_valid ? s_reg[LAST] : '0;
   assign cout      = out_valid & c_reg[LAST];
   assign borrow    = out_valid & m_reg[LAST] & ~c_reg[LAST];
   assign ovf       = out_valid
                    & (a_reg[LAST][N-1] == b_reg[LAST][N-1])
                    & (s_reg[LAST][N-1] != a_reg[LAST][N-1]);
   assign zero      = out_valid & ~(|s_reg[LAST]);

endmodule
